// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event path.
// PS2_ASCII_EN adds an 8-bit ASCII field to the queued event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Keyboard controller responses that never form part of a key sequence
  localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
  localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
`ifdef PS2_ASCII_EN
    logic [7:0] ascii;
`endif
  } ps2_event_t;

  function automatic logic is_response(input logic [7:0] code);
    logic r;
    case (code)
      PS2_RSP_BAT, PS2_RSP_ACK, PS2_RSP_ECHO,
      PS2_RSP_RESEND, PS2_RSP_ERR0, PS2_RSP_ERR1: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan-code (set 2) to ASCII lookup; letters honour shift.
// Only built when PS2_ASCII_EN is defined.
`ifdef PS2_ASCII_EN
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base_s;
  logic       letter_s;

  // Table lookup; letters are stored lower-case and folded to upper-case with shift
  always_comb begin
    base_s   = 8'h00;
    letter_s = 1'b0;
    if (ext) begin
      base_s   = 8'h00;
      letter_s = 1'b0;
    end else begin
      case (code)
        8'h1C: begin base_s = 8'h61; letter_s = 1'b1; end
        8'h32: begin base_s = 8'h62; letter_s = 1'b1; end
        8'h21: begin base_s = 8'h63; letter_s = 1'b1; end
        8'h23: begin base_s = 8'h64; letter_s = 1'b1; end
        8'h24: begin base_s = 8'h65; letter_s = 1'b1; end
        8'h2B: begin base_s = 8'h66; letter_s = 1'b1; end
        8'h34: begin base_s = 8'h67; letter_s = 1'b1; end
        8'h33: begin base_s = 8'h68; letter_s = 1'b1; end
        8'h43: begin base_s = 8'h69; letter_s = 1'b1; end
        8'h3B: begin base_s = 8'h6A; letter_s = 1'b1; end
        8'h42: begin base_s = 8'h6B; letter_s = 1'b1; end
        8'h4B: begin base_s = 8'h6C; letter_s = 1'b1; end
        8'h3A: begin base_s = 8'h6D; letter_s = 1'b1; end
        8'h31: begin base_s = 8'h6E; letter_s = 1'b1; end
        8'h44: begin base_s = 8'h6F; letter_s = 1'b1; end
        8'h4D: begin base_s = 8'h70; letter_s = 1'b1; end
        8'h15: begin base_s = 8'h71; letter_s = 1'b1; end
        8'h2D: begin base_s = 8'h72; letter_s = 1'b1; end
        8'h1B: begin base_s = 8'h73; letter_s = 1'b1; end
        8'h2C: begin base_s = 8'h74; letter_s = 1'b1; end
        8'h3C: begin base_s = 8'h75; letter_s = 1'b1; end
        8'h2A: begin base_s = 8'h76; letter_s = 1'b1; end
        8'h1D: begin base_s = 8'h77; letter_s = 1'b1; end
        8'h22: begin base_s = 8'h78; letter_s = 1'b1; end
        8'h35: begin base_s = 8'h79; letter_s = 1'b1; end
        8'h1A: begin base_s = 8'h7A; letter_s = 1'b1; end
        8'h16: base_s = 8'h31;
        8'h1E: base_s = 8'h32;
        8'h26: base_s = 8'h33;
        8'h25: base_s = 8'h34;
        8'h2E: base_s = 8'h35;
        8'h36: base_s = 8'h36;
        8'h3D: base_s = 8'h37;
        8'h3E: base_s = 8'h38;
        8'h46: base_s = 8'h39;
        8'h45: base_s = 8'h30;
        8'h29: base_s = 8'h20;
        8'h5A: base_s = 8'h0D;
        8'h66: base_s = 8'h08;
        default: begin
          base_s   = 8'h00;
          letter_s = 1'b0;
        end
      endcase
    end
  end

  assign ascii = (letter_s && shift) ? (base_s - 8'h20) : base_s;

endmodule
`endif

// File: rtl/ps2_key_event.sv
// Folds PS/2 scan-code bytes into make/break key events with repeat filtering,
// shift tracking and a ready/valid event FIFO. PS2_ASCII_EN adds ASCII decoding.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PRESS_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         code_in,
  input  logic               code_valid,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic [7:0]         ev_ascii,
  output logic               held,
  output logic               shift,
  output logic [PRESS_W-1:0] press_count,
  output logic               overflow
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  ps2_state_t         state_r, state_nxt_s;
  logic               make_s, brk_s, ext_s;
  logic               held_match_s, emit_make_s, emit_s;
  logic               full_s, push_s, pop_s, drop_s, ev_valid_s;
  logic               held_r, held_ext_r, lshift_r, rshift_r, overflow_r;
  logic [7:0]         held_code_r;
  logic [PRESS_W-1:0] press_cnt_r;
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]     count_r;
  ps2_event_t         mem_r [DEPTH];
  ps2_event_t         entry_s, head_s;

  // Prefix state machine: decides whether this byte completes a make or break
  always_comb begin
    state_nxt_s = state_r;
    make_s      = 1'b0;
    brk_s       = 1'b0;
    ext_s       = 1'b0;
    if (code_valid) begin
      case (state_r)
        S_IDLE: begin
          if (code_in == PS2_EXT) begin
            state_nxt_s = S_EXT;
          end else if (code_in == PS2_BRK) begin
            state_nxt_s = S_BRK;
          end else if (is_response(code_in)) begin
            state_nxt_s = S_IDLE;
          end else begin
            make_s = 1'b1;
          end
        end
        S_EXT: begin
          if (code_in == PS2_BRK) begin
            state_nxt_s = S_EXT_BRK;
          end else if (code_in == PS2_EXT) begin
            state_nxt_s = S_EXT;
          end else begin
            make_s      = 1'b1;
            ext_s       = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end
        S_BRK: begin
          if (code_in == PS2_EXT) begin
            state_nxt_s = S_EXT_BRK;
          end else if (code_in == PS2_BRK) begin
            state_nxt_s = S_BRK;
          end else begin
            brk_s       = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if ((code_in == PS2_EXT) || (code_in == PS2_BRK)) begin
            state_nxt_s = S_EXT_BRK;
          end else begin
            brk_s       = 1'b1;
            ext_s       = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign held_match_s = held_r && (held_code_r == code_in) && (held_ext_r == ext_s);
  assign emit_make_s  = make_s && !held_match_s;
  assign emit_s       = emit_make_s || brk_s;

  assign ev_valid_s = (count_r != '0);
  assign full_s     = (count_r == FULL_CNT);
  assign pop_s      = ev_valid_s && ev_ready;
  assign push_s     = emit_s && (!full_s || pop_s);
  assign drop_s     = emit_s && full_s && !pop_s;

`ifdef PS2_ASCII_EN
  logic [7:0] ascii_s;

  // ASCII uses the shift state as it was before this byte
  ps2_ascii_rom u_ascii_rom (
    .code  (code_in),
    .ext   (ext_s),
    .shift (lshift_r | rshift_r),
    .ascii (ascii_s)
  );
`endif

  // Assemble the FIFO entry for the event produced by this byte
  always_comb begin
    entry_s      = '0;
    entry_s.code = code_in;
    entry_s.ext  = ext_s;
    entry_s.brk  = brk_s;
`ifdef PS2_ASCII_EN
    entry_s.ascii = ascii_s;
`endif
  end

  // State, key tracking and FIFO storage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      held_r      <= 1'b0;
      held_ext_r  <= 1'b0;
      held_code_r <= 8'h00;
      lshift_r    <= 1'b0;
      rshift_r    <= 1'b0;
      press_cnt_r <= '0;
      overflow_r  <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;

      if (emit_make_s) begin
        held_r      <= 1'b1;
        held_code_r <= code_in;
        held_ext_r  <= ext_s;
        press_cnt_r <= press_cnt_r + 1'b1;
      end else if (brk_s && held_match_s) begin
        held_r <= 1'b0;
      end

      if (!ext_s && (code_in == PS2_LSHIFT) && (make_s || brk_s)) begin
        lshift_r <= make_s;
      end
      if (!ext_s && (code_in == PS2_RSHIFT) && (make_s || brk_s)) begin
        rshift_r <= make_s;
      end

      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase

      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head_s = mem_r[rd_ptr_r];

  // Present the head entry; an empty FIFO shows an all-zero event
  always_comb begin
    ev_code  = 8'h00;
    ev_ext   = 1'b0;
    ev_break = 1'b0;
    ev_ascii = 8'h00;
    if (ev_valid_s) begin
      ev_code  = head_s.code;
      ev_ext   = head_s.ext;
      ev_break = head_s.brk;
`ifdef PS2_ASCII_EN
      ev_ascii = head_s.ascii;
`else
      ev_ascii = 8'h00;
`endif
    end else begin
      ev_code  = 8'h00;
      ev_ext   = 1'b0;
      ev_break = 1'b0;
      ev_ascii = 8'h00;
    end
  end

  assign ev_valid    = ev_valid_s;
  assign held        = held_r;
  assign shift       = lshift_r | rshift_r;
  assign press_count = press_cnt_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed self-checking bench for ps2_key_event (default DEPTH=4, PRESS_W=8).
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;
  logic       held;
  logic       shift;
  logic [7:0] press_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

`ifdef PS2_ASCII_EN
  localparam logic [7:0] ASC_A_LO = 8'h61;
  localparam logic [7:0] ASC_A_UP = 8'h41;
`else
  localparam logic [7:0] ASC_A_LO = 8'h00;
  localparam logic [7:0] ASC_A_UP = 8'h00;
`endif

  ps2_key_event dut (
    .clk         (clk),
    .resetn      (resetn),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .ev_ascii    (ev_ascii),
    .held        (held),
    .shift       (shift),
    .press_count (press_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Record every event the consumer accepts: {code, ext, break, ascii}
  logic [17:0] q [$];
  always @(negedge clk) begin
    if (ev_valid && ev_ready) q.push_back({ev_code, ev_ext, ev_break, ev_ascii});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    code_in    = b;
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; code_in = 8'h00; code_valid = 1'b0; ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ev_valid, ev_code, ev_ext, ev_break, ev_ascii} !== 19'h0) begin
      fails++; $display("FAIL reset_ev: got %h expected 0", {ev_valid, ev_code, ev_ext, ev_break, ev_ascii});
    end
    tests++;
    if ({held, shift, press_count, overflow} !== 11'h0) begin
      fails++; $display("FAIL reset_status: got %h expected 0", {held, shift, press_count, overflow});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_make_break();
    ev_ready = 1'b1;
    send_byte(8'h1C);
    tests++;
    if (ev_valid !== 1'b1) begin fails++; $display("FAIL mb_valid: got %b expected 1", ev_valid); end
    tests++;
    if (held !== 1'b1) begin fails++; $display("FAIL mb_held_set: got %b expected 1", held); end
    tests++;
    if (press_count !== 8'd1) begin fails++; $display("FAIL mb_count: got %0d expected 1", press_count); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    tests++;
    if (held !== 1'b0) begin fails++; $display("FAIL mb_held_clr: got %b expected 0", held); end
    idle(3);
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL mb_events: got %0d expected 2", q.size());
    end else begin
      tests++;
      if (q[0] !== {8'h1C, 1'b0, 1'b0, ASC_A_LO}) begin fails++; $display("FAIL mb_make: got %h expected %h", q[0], {8'h1C, 1'b0, 1'b0, ASC_A_LO}); end
      tests++;
      if (q[1] !== {8'h1C, 1'b0, 1'b1, ASC_A_LO}) begin fails++; $display("FAIL mb_break: got %h expected %h", q[1], {8'h1C, 1'b0, 1'b1, ASC_A_LO}); end
    end
    tests++;
    if (press_count !== 8'd1) begin fails++; $display("FAIL mb_count_end: got %0d expected 1", press_count); end
  endtask

  task automatic test_repeat();
    apply_reset();
    ev_ready = 1'b1;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    idle(3);
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL rep_events: got %0d expected 2", q.size());
    end else begin
      tests++;
      if (q[1] !== {8'h1C, 1'b0, 1'b1, ASC_A_LO}) begin fails++; $display("FAIL rep_break: got %h expected %h", q[1], {8'h1C, 1'b0, 1'b1, ASC_A_LO}); end
    end
    tests++;
    if (press_count !== 8'd1) begin fails++; $display("FAIL rep_count: got %0d expected 1", press_count); end
  endtask

  task automatic test_shift();
    apply_reset();
    ev_ready = 1'b1;
    send_byte(8'h12);
    tests++;
    if (shift !== 1'b1) begin fails++; $display("FAIL sh_set: got %b expected 1", shift); end
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    tests++;
    if (shift !== 1'b1) begin fails++; $display("FAIL sh_hold: got %b expected 1", shift); end
    send_byte(8'hF0); send_byte(8'h12);
    tests++;
    if (shift !== 1'b0) begin fails++; $display("FAIL sh_clr: got %b expected 0", shift); end
    idle(3);
    tests++;
    if (q.size() != 4) begin
      fails++; $display("FAIL sh_events: got %0d expected 4", q.size());
    end else begin
      tests++;
      if (q[0] !== {8'h12, 1'b0, 1'b0, 8'h00}) begin fails++; $display("FAIL sh_make12: got %h expected %h", q[0], {8'h12, 1'b0, 1'b0, 8'h00}); end
      tests++;
      if (q[1] !== {8'h1C, 1'b0, 1'b0, ASC_A_UP}) begin fails++; $display("FAIL sh_make1c: got %h expected %h", q[1], {8'h1C, 1'b0, 1'b0, ASC_A_UP}); end
      tests++;
      if (q[3] !== {8'h12, 1'b0, 1'b1, 8'h00}) begin fails++; $display("FAIL sh_break12: got %h expected %h", q[3], {8'h12, 1'b0, 1'b1, 8'h00}); end
    end
    tests++;
    if (press_count !== 8'd2) begin fails++; $display("FAIL sh_count: got %0d expected 2", press_count); end
  endtask

  // Extended make/break delivered with code_valid high on consecutive cycles
  task automatic test_back_to_back();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    apply_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      code_in    = seq[i];
      code_valid = 1'b1;
    end
    @(posedge clk); #1;
    code_valid = 1'b0;
    idle(3);
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL ext_events: got %0d expected 2", q.size());
    end else begin
      tests++;
      if (q[0] !== {8'h75, 1'b1, 1'b0, 8'h00}) begin fails++; $display("FAIL ext_make: got %h expected %h", q[0], {8'h75, 1'b1, 1'b0, 8'h00}); end
      tests++;
      if (q[1] !== {8'h75, 1'b1, 1'b1, 8'h00}) begin fails++; $display("FAIL ext_break: got %h expected %h", q[1], {8'h75, 1'b1, 1'b1, 8'h00}); end
    end
    tests++;
    if ({held, press_count} !== {1'b0, 8'd1}) begin fails++; $display("FAIL ext_status: got %h expected %h", {held, press_count}, {1'b0, 8'd1}); end
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    apply_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(keys[i]);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ov_flag: got %b expected 1", overflow); end
    tests++;
    if ({ev_valid, ev_code} !== {1'b1, 8'h15}) begin fails++; $display("FAIL ov_head: got %h expected %h", {ev_valid, ev_code}, {1'b1, 8'h15}); end
    ev_ready = 1'b1;
    idle(6);
    tests++;
    if (q.size() != 4) begin
      fails++; $display("FAIL ov_events: got %0d expected 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (q[i][17:10] !== keys[i]) begin fails++; $display("FAIL ov_order%0d: got %h expected %h", i, q[i][17:10], keys[i]); end
      end
    end
    tests++;
    if ({ev_valid, overflow} !== 2'b01) begin fails++; $display("FAIL ov_after: got %b expected 01", {ev_valid, overflow}); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ev_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'hF0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ev_valid, ev_code, ev_ascii, held, shift, press_count, overflow} !== 28'h0) begin
      fails++; $display("FAIL rm_zero: got %h expected 0", {ev_valid, ev_code, ev_ascii, held, shift, press_count, overflow});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    q.delete();
    ev_ready = 1'b1;
    send_byte(8'h1C);
    idle(3);
    tests++;
    if (q.size() != 1) begin
      fails++; $display("FAIL rm_events: got %0d expected 1", q.size());
    end else begin
      tests++;
      if (q[0] !== {8'h1C, 1'b0, 1'b0, ASC_A_LO}) begin fails++; $display("FAIL rm_make: got %h expected %h", q[0], {8'h1C, 1'b0, 1'b0, ASC_A_LO}); end
    end
    tests++;
    if ({held, press_count} !== {1'b1, 8'd1}) begin fails++; $display("FAIL rm_status: got %h expected %h", {held, press_count}, {1'b1, 8'd1}); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_shift();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
